// File: rtl/mem_pkg.sv
// Shared types, default geometry and range check for the main-memory server.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

   localparam int LINE_WORDS_D  = 16;
   localparam int WORD_W_D      = 32;
   localparam int DEPTH_WORDS_D = 4096;

   localparam int LINE_W = LINE_WORDS_D * WORD_W_D;
   localparam int OFFS_W = $clog2(LINE_WORDS_D);
   localparam int IDX_W  = $clog2(DEPTH_WORDS_D);

   function automatic logic f_oor(input logic [63:0] widx,
                                  input int unsigned depth);
      return widx >= 64'(depth);
   endfunction

endpackage

// File: rtl/main_mem_server_if.sv
// Request/response bundle between the cache controller and main memory.
interface main_mem_server_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LW     = LINE_W
);
   logic [ADDR_W-1:0] main_mem_addr;
   logic              main_mem_read_req;
   logic              main_mem_write_req;
   logic              main_mem_line_wr;
   logic [LW-1:0]     main_mem_wdata;
   logic [LW-1:0]     main_mem_rdata;
   logic              main_mem_ready;
   logic              main_mem_busy;
   logic              main_mem_err;

   modport slave (
      input  main_mem_addr, main_mem_read_req, main_mem_write_req,
      input  main_mem_line_wr, main_mem_wdata,
      output main_mem_rdata, main_mem_ready, main_mem_busy, main_mem_err
   );

   modport master (
      output main_mem_addr, main_mem_read_req, main_mem_write_req,
      output main_mem_line_wr, main_mem_wdata,
      input  main_mem_rdata, main_mem_ready, main_mem_busy, main_mem_err
   );
endinterface

// File: rtl/mem_word_ram.sv
// Single-port word RAM, read-first, one-cycle registered read.
module mem_word_ram #(
   parameter int                WORD_W   = 32,
   parameter int                DEPTH    = 4096,
   parameter int                AW       = $clog2(DEPTH),
   parameter logic [WORD_W-1:0] INIT_VAL = '1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH] = '{default: INIT_VAL};

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/main_mem_server.sv
// Backing memory behind the L1: line refill, line write-back, word store,
// fixed wait latency and out-of-range error reporting.
module main_mem_server
   import mem_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                WORD_W      = LINE_W >> OFFS_W,
   parameter int                LINE_WORDS  = 1 << OFFS_W,
   parameter int                DEPTH_WORDS = 1 << IDX_W,
   parameter int                LATENCY     = 4,
   parameter logic [WORD_W-1:0] INIT_VAL    = '1
) (
   input logic              clk,
   input logic              rst_n,
   main_mem_server_if.slave bus
);
   localparam int SH     = $clog2(WORD_W / 8);
   localparam int OB     = $clog2(LINE_WORDS);
   localparam int IB     = $clog2(DEPTH_WORDS);
   localparam int LB     = LINE_WORDS * WORD_W;
   localparam int BW     = OB + 1;
   localparam int LAT_W  = $clog2(LATENCY + 1) + 1;
   localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_widx;
   logic              r_rd, r_line;
   logic [LB-1:0]     r_wdata, r_rdata;
   logic              r_ready, r_busy, r_err;
   logic [BW-1:0]     r_beat;
   logic [LAT_W-1:0]  r_wait;

   logic              w_acc, w_oor, w_issue, w_we;
   logic [BW-1:0]     w_beats;
   logic [OB-1:0]     w_off, w_cap;
   logic [IB-1:0]     w_ram_addr;
   logic [WORD_W-1:0] w_wword, w_ram_rd;

   assign w_acc   = (r_state == IDLE) &&
                    (bus.main_mem_read_req || bus.main_mem_write_req);
   assign w_oor   = f_oor(64'(r_widx), DEPTH_WORDS);
   assign w_beats = (w_oor || (!r_rd && !r_line)) ? BW'(1) : BW'(LINE_WORDS);
   assign w_off   = r_beat[OB-1:0];
   assign w_cap   = w_off - OB'(1);
   assign w_issue = (r_state == XFER) && (r_beat != w_beats);
   assign w_we    = w_issue && !r_rd && !w_oor;
   assign w_wword = r_wdata[w_off*WORD_W +: WORD_W];
   assign w_ram_addr = (r_rd || r_line) ? {r_widx[IB-1:OB], w_off}
                                        : r_widx[IB-1:0];

   mem_word_ram #(
      .WORD_W  (WORD_W),
      .DEPTH   (DEPTH_WORDS),
      .AW      (IB),
      .INIT_VAL(INIT_VAL)
   ) u_ram (
      .clk    (clk),
      .i_we   (w_we),
      .i_addr (w_ram_addr),
      .i_wdata(w_wword),
      .o_rdata(w_ram_rd)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_acc) w_next = (LATENCY == 0) ? XFER : WAIT;
         WAIT: if (r_wait == LAT_W'(LAT_M1)) w_next = XFER;
         XFER: if (r_beat == w_beats) w_next = DONE;
         DONE: w_next = IDLE;
      endcase
   end

   // Read data trails the RAM address by one beat; the extra XFER cycle
   // at r_beat == w_beats drains the last word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_widx  <= '0;
         r_rd    <= 1'b0;
         r_line  <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_beat  <= '0;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == DONE);
         r_busy  <= (w_next != IDLE);
         r_err   <= (w_next == DONE) && w_oor;
         if (w_acc) begin
            r_widx  <= bus.main_mem_addr >> SH;
            r_rd    <= bus.main_mem_read_req;
            r_line  <= bus.main_mem_line_wr;
            r_wdata <= bus.main_mem_wdata;
            r_wait  <= '0;
            r_beat  <= '0;
         end
         if (r_state == WAIT) r_wait <= r_wait + LAT_W'(1);
         if (w_issue) r_beat <= r_beat + BW'(1);
         if ((r_state == XFER) && r_rd && (r_beat != '0)) begin
            if (w_oor) r_rdata <= {LINE_WORDS{INIT_VAL}};
            else r_rdata[w_cap*WORD_W +: WORD_W] <= w_ram_rd;
         end
      end
   end

   assign bus.main_mem_rdata = r_rdata;
   assign bus.main_mem_ready = r_ready;
   assign bus.main_mem_busy  = r_busy;
   assign bus.main_mem_err   = r_err;
endmodule
